// File: rtl/csr_rmw_unit_if.sv
// Request/response handshake bundle between an instruction pipeline and csr_rmw_unit.
interface csr_rmw_unit_if #(
    parameter int unsigned C_XLEN = 32
);
    localparam int unsigned ADDR_W = 12;

    logic              req_valid_i;
    logic              req_ready_o;
    logic [1:0]        req_op_i;
    logic              req_imm_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [C_XLEN-1:0] req_src_i;
    logic              req_src_zero_i;
    logic              req_rd_zero_i;

    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [C_XLEN-1:0] rsp_data_o;
    logic              rsp_exc_o;

    modport master (
        output req_valid_i, req_op_i, req_imm_i, req_addr_i, req_src_i,
               req_src_zero_i, req_rd_zero_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_exc_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_imm_i, req_addr_i, req_src_i,
               req_src_zero_i, req_rd_zero_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_exc_o
    );
endinterface

// File: rtl/csr_rmw_unit.sv
// CSR read-modify-write sequencer (CSRRW/CSRRS/CSRRC): IDLE -> READ -> WRITE -> RESP.
// Optional macro CSR_RMW_RO_CHECK_EN: flag writes to addr[11:10]=2'b11 locally as illegal.
module csr_rmw_unit #(
    parameter int unsigned C_XLEN = 32
) (
    input  logic              clk_i,
    input  logic              resetb_i,
    input  logic              clk_en_i,
    csr_rmw_unit_if.slave     bus,
    output logic              csr_rd_o,
    output logic [11:0]       csr_rd_addr_o,
    input  logic [C_XLEN-1:0] csr_rd_data_i,
    input  logic              csr_illegal_rd_i,
    output logic              csr_wr_o,
    output logic [11:0]       csr_wr_addr_o,
    output logic [C_XLEN-1:0] csr_wr_data_o,
    input  logic              csr_illegal_wr_i
);
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned UIMM_W = 5;

    localparam logic [1:0] OP_ILL = 2'b00;
    localparam logic [1:0] OP_RW  = 2'b01;
    localparam logic [1:0] OP_RS  = 2'b10;
    localparam logic [1:0] OP_RC  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [1:0]          op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [C_XLEN-1:0]   src_q;
    logic [C_XLEN-1:0]   old_q;
    logic                src_zero_q;
    logic                rd_zero_q;
    logic                exc_q;

    logic                accept_c;
    logic                read_en_c;
    logic                rd_exc_c;
    logic                wr_suppress_c;
    logic                ro_hit_c;
    logic                wr_exc_c;
    logic [C_XLEN-1:0]   src_fmt_c;
    logic [C_XLEN-1:0]   new_val_c;

    assign accept_c = (state == S_IDLE) && bus.req_valid_i && clk_en_i;

    // Immediate forms carry a 5-bit zero-extended uimm in the low source bits.
    assign src_fmt_c = bus.req_imm_i ? C_XLEN'(bus.req_src_i[UIMM_W-1:0]) : bus.req_src_i;

    // CSRRW with rd=x0 must not cause read side effects.
    assign read_en_c = !((op_q == OP_RW) && rd_zero_q);
    assign rd_exc_c  = (op_q == OP_ILL) || (read_en_c && csr_illegal_rd_i);

    assign wr_suppress_c = exc_q || (((op_q == OP_RS) || (op_q == OP_RC)) && src_zero_q);

`ifdef CSR_RMW_RO_CHECK_EN
    assign ro_hit_c = (addr_q[ADDR_W-1:ADDR_W-2] == 2'b11);
`else
    assign ro_hit_c = 1'b0;
`endif

    // A local read-only hit already flags the write, so csr_illegal_wr_i is moot there.
    assign wr_exc_c = !wr_suppress_c && (ro_hit_c || csr_illegal_wr_i);

    always_comb begin
        new_val_c = old_q & ~src_q;
        case (op_q)
            OP_RW:   new_val_c = src_q;
            OP_RS:   new_val_c = old_q | src_q;
            OP_RC:   new_val_c = old_q & ~src_q;
            default: new_val_c = old_q & ~src_q;
        endcase
    end

    // State register; clk_en_i low freezes the sequence.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state <= S_IDLE;
        end else if (clk_en_i) begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.req_valid_i) state_nxt = S_READ;
            S_READ:  state_nxt = S_WRITE;
            S_WRITE: state_nxt = S_RESP;
            S_RESP:  if (bus.rsp_ready_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode; strobes are qualified by clk_en_i so a frozen cycle issues nothing.
    always_comb begin
        bus.req_ready_o  = 1'b0;
        bus.rsp_valid_o  = 1'b0;
        bus.rsp_data_o   = '0;
        bus.rsp_exc_o    = 1'b0;
        csr_rd_o         = 1'b0;
        csr_wr_o         = 1'b0;
        csr_rd_addr_o    = addr_q;
        csr_wr_addr_o    = addr_q;
        csr_wr_data_o    = new_val_c;
        case (state)
            S_IDLE:  bus.req_ready_o = resetb_i;
            S_READ:  csr_rd_o = clk_en_i && read_en_c;
            S_WRITE: csr_wr_o = clk_en_i && !wr_suppress_c && !ro_hit_c;
            S_RESP: begin
                bus.rsp_valid_o = 1'b1;
                bus.rsp_exc_o   = exc_q;
                bus.rsp_data_o  = exc_q ? '0 : old_q;
            end
            default: ;
        endcase
    end

    // Transaction context and captured old value.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            op_q       <= OP_ILL;
            addr_q     <= '0;
            src_q      <= '0;
            old_q      <= '0;
            src_zero_q <= 1'b0;
            rd_zero_q  <= 1'b0;
            exc_q      <= 1'b0;
        end else if (clk_en_i) begin
            if (accept_c) begin
                op_q       <= bus.req_op_i;
                addr_q     <= bus.req_addr_i;
                src_q      <= src_fmt_c;
                src_zero_q <= bus.req_src_zero_i;
                rd_zero_q  <= bus.req_rd_zero_i;
                exc_q      <= 1'b0;
            end else if (state == S_READ) begin
                old_q <= read_en_c ? csr_rd_data_i : '0;
                exc_q <= rd_exc_c;
            end else if (state == S_WRITE) begin
                exc_q <= exc_q || wr_exc_c;
            end
        end
    end
endmodule

// File: tb/tb_csr_rmw_unit.sv
// Self-checking bench for csr_rmw_unit: directed vector table, corner sequences, random vs model.
module tb_csr_rmw_unit;
    localparam int unsigned XLEN = 32;

    typedef struct {
        logic [1:0]      op;
        logic            imm;
        logic [11:0]     addr;
        logic [XLEN-1:0] src;
        logic            src_zero;
        logic            rd_zero;
        logic [XLEN-1:0] csr_val;
        logic            ill_rd;
        logic            ill_wr;
    } req_t;

    typedef struct {
        int              n_rd;
        int              n_wr;
        logic [XLEN-1:0] wdata;
        logic [XLEN-1:0] rdata;
        logic            exc;
    } exp_t;

    typedef struct {
        req_t rq;
        exp_t ex;
    } vec_t;

    logic            clk = 1'b0;
    logic            resetb;
    logic            clk_en;
    logic            csr_rd;
    logic            csr_wr;
    logic [11:0]     csr_rd_addr;
    logic [11:0]     csr_wr_addr;
    logic [XLEN-1:0] csr_rd_data;
    logic [XLEN-1:0] csr_wr_data;
    logic            ill_rd;
    logic            ill_wr;
    logic [11:0]     cur_addr;
    logic [XLEN-1:0] cur_val;

    int              n_cmp = 0;
    int              n_bad = 0;
    int              rd_cnt = 0;
    int              wr_cnt = 0;
    logic [11:0]     last_rd_addr = '0;
    logic [11:0]     last_wr_addr = '0;
    logic [XLEN-1:0] last_wr_data = '0;

    csr_rmw_unit_if #(.C_XLEN(XLEN)) bus();

    csr_rmw_unit #(.C_XLEN(XLEN)) dut (
        .clk_i            (clk),
        .resetb_i         (resetb),
        .clk_en_i         (clk_en),
        .bus              (bus),
        .csr_rd_o         (csr_rd),
        .csr_rd_addr_o    (csr_rd_addr),
        .csr_rd_data_i    (csr_rd_data),
        .csr_illegal_rd_i (ill_rd),
        .csr_wr_o         (csr_wr),
        .csr_wr_addr_o    (csr_wr_addr),
        .csr_wr_data_o    (csr_wr_data),
        .csr_illegal_wr_i (ill_wr)
    );

    always #5 clk = ~clk;

    // CSR file stand-in: only the addressed register returns the planted value.
    assign csr_rd_data = (csr_rd_addr == cur_addr) ? cur_val : ~cur_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (csr_rd) begin
            rd_cnt++;
            last_rd_addr = csr_rd_addr;
        end
        if (csr_wr) begin
            wr_cnt++;
            last_wr_addr = csr_wr_addr;
            last_wr_data = csr_wr_data;
        end
        if (csr_rd || csr_wr) check("rd_wr_exclusive", 32'(csr_rd & csr_wr), 32'd0);
        if (!clk_en) check("strobe_while_gated", 32'({csr_rd, csr_wr}), 32'd0);
    end

    // Reference: architectural CSRRW/RS/RC semantics.
    function automatic exp_t model(input req_t r);
        exp_t            e;
        logic [XLEN-1:0] s;
        logic [XLEN-1:0] old;
        logic            do_rd;
        logic            exc;
        logic            supp;
        logic            ro;
        s     = r.imm ? {27'b0, r.src[4:0]} : r.src;
        do_rd = !(r.op == 2'b01 && r.rd_zero);
        old   = do_rd ? r.csr_val : '0;
        exc   = (r.op == 2'b00) || (do_rd && r.ill_rd);
        supp  = exc || ((r.op == 2'b10 || r.op == 2'b11) && r.src_zero);
`ifdef CSR_RMW_RO_CHECK_EN
        ro = (r.addr >= 12'hC00);
`else
        ro = 1'b0;
`endif
        case (r.op)
            2'b01:   e.wdata = s;
            2'b10:   e.wdata = old | s;
            default: e.wdata = old & ~s;
        endcase
        e.n_rd  = do_rd ? 1 : 0;
        e.n_wr  = (!supp && !ro) ? 1 : 0;
        e.exc   = exc || (!supp && (ro || r.ill_wr));
        e.rdata = e.exc ? '0 : old;
        return e;
    endfunction

    function automatic vec_t mk(input logic [1:0] op, input logic imm, input logic [11:0] addr,
                                input logic [31:0] src, input logic sz, input logic rz,
                                input logic [31:0] val, input logic ir, input logic iw,
                                input int nrd, input int nwr, input logic [31:0] wd,
                                input logic [31:0] rd, input logic exc);
        vec_t v;
        v.rq = '{op, imm, addr, src, sz, rz, val, ir, iw};
        v.ex = '{nrd, nwr, wd, rd, exc};
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run_txn(input string tag, input req_t r, input exp_t e,
                           input int rdy_delay, input bit jitter, input int read_stall);
        int              rd0;
        int              wr0;
        int              cyc;
        bit              ok;
        logic [XLEN-1:0] hold_data;
        logic            hold_exc;
        cur_addr = r.addr;
        cur_val  = r.csr_val;
        ill_rd   = r.ill_rd;
        ill_wr   = r.ill_wr;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        bus.req_valid_i    = 1'b1;
        bus.req_op_i       = r.op;
        bus.req_imm_i      = r.imm;
        bus.req_addr_i     = r.addr;
        bus.req_src_i      = r.src;
        bus.req_src_zero_i = r.src_zero;
        bus.req_rd_zero_i  = r.rd_zero;
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < 50) begin
            clk_en = jitter ? ($urandom_range(0, 3) != 0) : 1'b1;
            ok = bus.req_ready_o && clk_en;
            step();
            cyc++;
        end
        check({tag, "_accept"}, 32'(ok), 32'd1);
        // Scramble the request bus so only latched values can be used.
        bus.req_valid_i    = 1'b0;
        bus.req_op_i       = 2'($urandom_range(0, 3));
        bus.req_addr_i     = 12'($urandom());
        bus.req_src_i      = $urandom();
        bus.req_imm_i      = ~r.imm;
        bus.req_src_zero_i = ~r.src_zero;
        bus.req_rd_zero_i  = ~r.rd_zero;
        for (int i = 0; i < read_stall; i++) begin
            clk_en = 1'b0;
            step();
        end
        cyc = 0;
        while (!bus.rsp_valid_o && cyc < 50) begin
            clk_en = jitter ? ($urandom_range(0, 3) != 0) : 1'b1;
            step();
            cyc++;
        end
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid_o), 32'd1);
        if (!jitter) check({tag, "_latency"}, 32'(cyc), 32'd2);
        check({tag, "_rsp_data"}, bus.rsp_data_o, e.rdata);
        check({tag, "_rsp_exc"}, 32'(bus.rsp_exc_o), 32'(e.exc));
        check({tag, "_n_rd"}, 32'(rd_cnt - rd0), 32'(e.n_rd));
        check({tag, "_n_wr"}, 32'(wr_cnt - wr0), 32'(e.n_wr));
        if (e.n_rd != 0) check({tag, "_rd_addr"}, 32'(last_rd_addr), 32'(r.addr));
        if (e.n_wr != 0) begin
            check({tag, "_wr_addr"}, 32'(last_wr_addr), 32'(r.addr));
            check({tag, "_wr_data"}, last_wr_data, e.wdata);
        end
        bus.rsp_ready_i = 1'b0;
        hold_data = bus.rsp_data_o;
        hold_exc  = bus.rsp_exc_o;
        for (int i = 0; i < rdy_delay; i++) begin
            clk_en = jitter ? ($urandom_range(0, 1) != 0) : 1'b1;
            step();
            check({tag, "_hold_valid"}, 32'(bus.rsp_valid_o), 32'd1);
            check({tag, "_hold_data"}, bus.rsp_data_o, hold_data);
            check({tag, "_hold_exc"}, 32'(bus.rsp_exc_o), 32'(hold_exc));
        end
        bus.rsp_ready_i = 1'b1;
        cyc = 0;
        while (bus.rsp_valid_o && cyc < 50) begin
            clk_en = jitter ? ($urandom_range(0, 3) != 0) : 1'b1;
            step();
            cyc++;
        end
        bus.rsp_ready_i = 1'b0;
        clk_en = 1'b1;
        check({tag, "_rsp_done"}, 32'(bus.rsp_valid_o), 32'd0);
        check({tag, "_ready_again"}, 32'(bus.req_ready_o), 32'd1);
    endtask

    vec_t vecs [12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        req_t r;
        exp_t e;
        int   rd0;
        int   wr0;

        vecs[0]  = mk(2'b10, 1'b0, 12'h300, 32'h0000_0008, 1'b0, 1'b0, 32'h0000_1800, 1'b0, 1'b0,
                      1, 1, 32'h0000_1808, 32'h0000_1800, 1'b0);
        vecs[1]  = mk(2'b11, 1'b0, 12'h300, 32'h0, 1'b1, 1'b0, 32'h0000_00FF, 1'b0, 1'b0,
                      1, 0, 32'h0000_00FF, 32'h0000_00FF, 1'b0);
        vecs[2]  = mk(2'b01, 1'b1, 12'h340, 32'h0000_001F, 1'b0, 1'b1, 32'h0000_1234, 1'b0, 1'b0,
                      0, 1, 32'h0000_001F, 32'h0, 1'b0);
`ifdef CSR_RMW_RO_CHECK_EN
        vecs[3]  = mk(2'b01, 1'b0, 12'hC00, 32'h1, 1'b0, 1'b0, 32'h55, 1'b0, 1'b1,
                      1, 0, 32'h1, 32'h0, 1'b1);
`else
        vecs[3]  = mk(2'b01, 1'b0, 12'hC00, 32'h1, 1'b0, 1'b0, 32'h55, 1'b0, 1'b1,
                      1, 1, 32'h1, 32'h0, 1'b1);
`endif
        vecs[4]  = mk(2'b00, 1'b0, 12'h300, 32'h5, 1'b0, 1'b0, 32'h77, 1'b0, 1'b0,
                      1, 0, 32'h0, 32'h0, 1'b1);
        vecs[5]  = mk(2'b10, 1'b0, 12'h7C0, 32'h3, 1'b0, 1'b0, 32'hAA, 1'b1, 1'b0,
                      1, 0, 32'h0, 32'h0, 1'b1);
        vecs[6]  = mk(2'b11, 1'b0, 12'h305, 32'h0000_00F0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0,
                      1, 1, 32'hFFFF_FF0F, 32'hFFFF_FFFF, 1'b0);
        vecs[7]  = mk(2'b10, 1'b1, 12'h340, 32'hABCD_EF3F, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0,
                      1, 1, 32'h0000_011F, 32'h0000_0100, 1'b0);
        vecs[8]  = mk(2'b01, 1'b0, 12'h341, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0,
                      1, 1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        vecs[9]  = mk(2'b01, 1'b0, 12'h342, 32'h0, 1'b1, 1'b0, 32'h42, 1'b0, 1'b0,
                      1, 1, 32'h0, 32'h42, 1'b0);
        vecs[10] = mk(2'b10, 1'b0, 12'h300, 32'h1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1,
                      1, 1, 32'h1, 32'h0, 1'b1);
        vecs[11] = mk(2'b11, 1'b0, 12'hC01, 32'h0, 1'b1, 1'b0, 32'h9, 1'b0, 1'b0,
                      1, 0, 32'h9, 32'h9, 1'b0);

        resetb = 1'b0;
        clk_en = 1'b0;
        ill_rd = 1'b0;
        ill_wr = 1'b0;
        cur_addr = '0;
        cur_val  = '0;
        bus.req_valid_i    = 1'b0;
        bus.req_op_i       = 2'b00;
        bus.req_imm_i      = 1'b0;
        bus.req_addr_i     = '0;
        bus.req_src_i      = '0;
        bus.req_src_zero_i = 1'b0;
        bus.req_rd_zero_i  = 1'b0;
        bus.rsp_ready_i    = 1'b0;
        #1;
        check("rst_ready", 32'(bus.req_ready_o), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rst_rsp_data", bus.rsp_data_o, 32'd0);
        check("rst_rsp_exc", 32'(bus.rsp_exc_o), 32'd0);
        check("rst_strobes", 32'({csr_rd, csr_wr}), 32'd0);
        check("rst_rd_addr", 32'(csr_rd_addr), 32'd0);
        check("rst_wr_data", csr_wr_data, 32'd0);
        repeat (3) step();
        resetb = 1'b1;
        clk_en = 1'b1;
        #1;
        check("rel_ready", 32'(bus.req_ready_o), 32'd1);
        step();

        for (int i = 0; i < 12; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].rq, vecs[i].ex, i % 3, 1'b0, 0);

        // Gated enable: a valid request must not be taken while clk_en is low.
        rd0 = rd_cnt;
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = 2'b10;
        clk_en = 1'b0;
        repeat (3) step();
        bus.req_valid_i = 1'b0;
        clk_en = 1'b1;
        repeat (3) step();
        check("gated_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
        check("gated_no_read", 32'(rd_cnt - rd0), 32'd0);
        check("gated_ready", 32'(bus.req_ready_o), 32'd1);

        // Read stalled by clk_en, response back-pressured for 5 cycles.
        run_txn("stall", vecs[0].rq, vecs[0].ex, 5, 1'b0, 3);

        // Reset in the middle of WRITE abandons the transaction.
        r = vecs[0].rq;
        cur_addr = r.addr;
        cur_val  = r.csr_val;
        bus.req_valid_i    = 1'b1;
        bus.req_op_i       = r.op;
        bus.req_imm_i      = r.imm;
        bus.req_addr_i     = r.addr;
        bus.req_src_i      = r.src;
        bus.req_src_zero_i = r.src_zero;
        bus.req_rd_zero_i  = r.rd_zero;
        clk_en = 1'b1;
        step();
        bus.req_valid_i = 1'b0;
        step();
        check("mid_wr_strobe", 32'(csr_wr), 32'd1);
        wr0 = wr_cnt;
        resetb = 1'b0;
        #1;
        check("mid_rst_wr", 32'(csr_wr), 32'd0);
        check("mid_rst_ready", 32'(bus.req_ready_o), 32'd0);
        step();
        step();
        resetb = 1'b1;
        #1;
        check("post_rst_ready", 32'(bus.req_ready_o), 32'd1);
        check("post_rst_wr_addr", 32'(csr_wr_addr), 32'd0);
        check("post_rst_rsp_data", bus.rsp_data_o, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
        end
        check("post_rst_no_write", 32'(wr_cnt - wr0), 32'd0);
        run_txn("recover", vecs[8].rq, vecs[8].ex, 1, 1'b0, 0);

        for (int i = 0; i < 150; i++) begin
            r.op       = 2'($urandom_range(0, 3));
            r.imm      = ($urandom_range(0, 1) != 0);
            r.addr     = ($urandom_range(0, 3) == 0) ? (12'hC00 | 12'($urandom_range(0, 1023)))
                                                     : 12'($urandom_range(0, 3071));
            r.src_zero = ($urandom_range(0, 3) == 0);
            r.src      = r.src_zero ? '0 : $urandom();
            r.rd_zero  = ($urandom_range(0, 3) == 0);
            r.csr_val  = $urandom();
            r.ill_rd   = ($urandom_range(0, 7) == 0);
            r.ill_wr   = ($urandom_range(0, 7) == 0);
            e = model(r);
            run_txn($sformatf("rnd%0d", i), r, e, $urandom_range(0, 3), (i >= 50),
                    (i < 50) ? $urandom_range(0, 2) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
